bpf_forwarder: RTL

- Downstream consumer of the bpfvm packet buffer.
- When the VM signals an accepted packet (ready_for_forwarder), the block reads the packet out of packet memory through the forwarder read port and emits it as a 64-bit AXI4-Stream.
- After the final beat is accepted it pulses forwarder_done, which hands the buffer back to the VM.
- Includes a 2-entry output buffer so downstream backpressure never drops or duplicates memory reads.

---
 rtl/bpf_forwarder.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/bpf_forwarder.sv
// Reads an accepted packet out of bpfvm packet memory and streams it as 64-bit AXI4-Stream.
// Define BPF_FORWARDER_STATS_EN to add the stat_pkts / stat_bytes counters.
module bpf_forwarder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 13,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ready_for_forwarder,
    input  logic [LEN_WIDTH-1:0]  pkt_len,
    output logic [ADDR_WIDTH-1:0] forwarder_rd_addr,
    output logic                  forwarder_rd_en,
    input  logic [63:0]           forwarder_rd_data,
    output logic                  forwarder_done,
    output logic [63:0]           m_tdata,
    output logic [7:0]            m_tkeep,
    output logic                  m_tlast,
    output logic                  m_tvalid,
    input  logic                  m_tready
`ifdef BPF_FORWARDER_STATS_EN
    ,
    output logic [31:0]           stat_pkts,
    output logic [31:0]           stat_bytes
`endif
);

    localparam int BW = ADDR_WIDTH + 1;
    localparam int CW = (LEN_WIDTH > ADDR_WIDTH + 4) ? LEN_WIDTH : ADDR_WIDTH + 4;
    localparam logic [CW-1:0] MAX_LEN = CW'(8) << ADDR_WIDTH;

    if (RD_LATENCY != 1) begin : g_lat_chk
        $error("bpf_forwarder supports RD_LATENCY == 1 only");
    end

    typedef enum logic [2:0] {IDLE, CALC, READ, DRAIN, DONE, HOLD} state_t;

    state_t               state, state_nxt;
    logic [LEN_WIDTH-1:0] len_q;
    logic [BW-1:0]        beats_q, issue_cnt;
    logic [7:0]           lastkeep_q;
    logic                 inflight, inflight_last;
    logic [63:0]          buf_data [2];
    logic [1:0]           buf_last;
    logic                 wr_ptr, rd_ptr;
    logic [1:0]           buf_count;

    logic [CW-1:0]        len_ext, len_clamp;
    logic [BW-1:0]        beats_calc;
    logic [7:0]           keep_calc;
    logic                 issue_last, head_valid, head_last, push, pop;
    logic [63:0]          head_data;

    always_comb begin
        len_ext    = CW'(len_q);
        len_clamp  = (len_ext > MAX_LEN) ? MAX_LEN : len_ext;
        beats_calc = BW'((len_clamp + CW'(7)) >> 3);
        keep_calc  = (len_clamp[2:0] == 3'd0) ? 8'hFF
                   : 8'(8'hFF << (4'd8 - {1'b0, len_clamp[2:0]}));
    end

    // Reads are throttled so buffered beats plus the one in flight never exceed two.
    always_comb begin
        issue_last        = (issue_cnt == beats_q - BW'(1));
        forwarder_rd_en   = (state == READ) && (issue_cnt < beats_q)
                          && ((buf_count + {1'b0, inflight}) < 2'd2);
        forwarder_rd_addr = forwarder_rd_en ? issue_cnt[ADDR_WIDTH-1:0] : '0;
        forwarder_done    = (state == DONE);
    end

    // Fall-through buffer: with nothing stored, the returning read beat is the head.
    always_comb begin
        head_valid = (buf_count != 2'd0) || inflight;
        head_data  = (buf_count != 2'd0) ? buf_data[rd_ptr] : forwarder_rd_data;
        head_last  = (buf_count != 2'd0) ? buf_last[rd_ptr] : inflight_last;
        push       = inflight;
        pop        = head_valid && m_tready;
        m_tvalid   = head_valid;
        m_tdata    = head_valid ? head_data : '0;
        m_tlast    = head_valid && head_last;
        m_tkeep    = !head_valid ? 8'h00 : (head_last ? lastkeep_q : 8'hFF);
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (ready_for_forwarder) state_nxt = CALC;
            CALC:    state_nxt = (beats_calc == '0) ? DONE : READ;
            READ:    if (forwarder_rd_en && issue_last) state_nxt = DRAIN;
            DRAIN:   if (pop && head_last) state_nxt = DONE;
            DONE:    state_nxt = HOLD;
            HOLD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            len_q         <= '0;
            beats_q       <= '0;
            lastkeep_q    <= '0;
            issue_cnt     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            buf_count     <= '0;
            buf_last      <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && ready_for_forwarder) len_q <= pkt_len;
            if (state == CALC) begin
                beats_q    <= beats_calc;
                lastkeep_q <= keep_calc;
                issue_cnt  <= '0;
            end else if (forwarder_rd_en) begin
                issue_cnt <= issue_cnt + BW'(1);
            end
            inflight      <= forwarder_rd_en;
            inflight_last <= forwarder_rd_en && issue_last;
            if (push) begin
                buf_last[wr_ptr] <= inflight_last;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            buf_count <= buf_count + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) buf_data[wr_ptr] <= forwarder_rd_data;
    end

`ifdef BPF_FORWARDER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_pkts  <= '0;
            stat_bytes <= '0;
        end else if (state == DONE) begin
            stat_pkts  <= stat_pkts + 32'd1;
            stat_bytes <= stat_bytes + 32'(len_q);
        end
    end
`endif

endmodule
